// File: rtl/snd_cmd_pkg.sv
// snd_cmd_pkg: shared constants and types for the sound command host.
// Port offsets and sender FSM states.
package snd_cmd_pkg;

  localparam logic [3:0] PORT_CMD    = 4'h0;
  localparam logic [3:0] PORT_REPLY  = 4'h8;
  localparam logic [3:0] PORT_STATUS = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } snd_tx_state_t;

endpackage

// File: rtl/snd_cmd_fifo.sv
// snd_cmd_fifo: small synchronous command queue, register array.
// Push while full is accepted only when a pop happens the same cycle.
module snd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [4:0]   cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [4:0]    cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == 5'd0);
  assign full_o  = (cnt_q == 5'(DEPTH));
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rp_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      if (do_push && !do_pop) cnt_q <= cnt_q + 5'd1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 5'd1;
    end
  end

endmodule

// File: rtl/snd_cmd_host.sv
// snd_cmd_host: main-CPU endpoint of the sound command/reply latches.
// Paced command queue toward the sound board, reply capture with IRQ.
module snd_cmd_host
  import snd_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int PACE_CYCLES = 256
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        paused,
  input  logic        io_sel,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [3:0]  io_addr,
  input  logic [15:0] io_din,
  input  logic [1:0]  io_be,
  output logic [15:0] io_dout,
  output logic        irq_req,
  input  logic        irq_ack,
  output logic        latch_wr,
  output logic [7:0]  latch_din,
  output logic        latch_rd,
  input  logic [7:0]  latch_dout,
  input  logic        latch_rdy
);

  localparam int PW = $clog2(PACE_CYCLES + 1);
  localparam logic [PW-1:0] PACE_LOAD = PW'(PACE_CYCLES - 1);
  localparam logic [PW-1:0] PACE_EXIT = PW'(2);

  snd_tx_state_t state_q, state_d;
  logic [PW-1:0] pace_q, pace_d;

  logic       wr_cmd, rd_stb, rd_reply, rd_status;
  logic       pop, f_full, f_empty, ovf_set;
  logic [7:0] f_head;
  logic [4:0] f_cnt;

  logic       rdy_q, rdy2_q, cap;
  logic [7:0] reply_q, reply_d;
  logic       valid_q, valid_d;
  logic       irq_q, irq_d;
  logic       ovf_q, ovf_d;
  logic       unused;

  assign unused = ^{io_din[15:8], io_be[1]};

  assign wr_cmd    = io_sel && io_wr && io_be[0] && (io_addr == PORT_CMD);
  assign rd_stb    = io_sel && io_rd;
  assign rd_reply  = rd_stb && (io_addr == PORT_REPLY);
  assign rd_status = rd_stb && (io_addr == PORT_STATUS);

  snd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (8)
  ) u_fifo (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .push_i (wr_cmd),
    .data_i (io_din[7:0]),
    .pop_i  (pop),
    .head_o (f_head),
    .full_o (f_full),
    .empty_o(f_empty),
    .cnt_o  (f_cnt)
  );

  // SEND and the IDLE re-entry each take one cycle of the pacing window,
  // so HOLD leaves after PACE_CYCLES-2 unpaused cycles.
  always_comb begin
    state_d   = state_q;
    pace_d    = pace_q;
    pop       = 1'b0;
    latch_wr  = 1'b0;
    latch_din = 8'h00;
    unique case (state_q)
      IDLE: if (!f_empty) state_d = SEND;
      SEND: begin
        latch_wr  = 1'b1;
        latch_din = f_head;
        pop       = 1'b1;
        pace_d    = PACE_LOAD;
        state_d   = (PACE_CYCLES == 2) ? IDLE : HOLD;
      end
      HOLD: begin
        if (!paused) begin
          pace_d = pace_q - 1'b1;
          if (pace_q <= PACE_EXIT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_set = wr_cmd && f_full && !pop;
  assign ovf_d   = ovf_set || (ovf_q && !rd_status);

  // Capture wins over a same-cycle clear.
  assign cap     = rdy_q && !rdy2_q;
  assign reply_d = cap ? latch_dout : reply_q;
  assign valid_d = cap || (valid_q && !rd_reply);
  assign irq_d   = cap || (irq_q && !rd_reply && !irq_ack);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pace_q  <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdy2_q  <= 1'b0;
      reply_q <= 8'h00;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pace_q  <= pace_d;
      ovf_q   <= ovf_d;
      rdy_q   <= latch_rdy;
      rdy2_q  <= rdy_q;
      reply_q <= reply_d;
      valid_q <= valid_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_req  = irq_q;
  assign latch_rd = rd_reply;

  always_comb begin
    io_dout = 16'hffff;
    unique case (1'b1)
      rd_reply:  io_dout = {8'hff, reply_q};
      rd_status: io_dout = {8'hff, ovf_q, 2'b00, f_cnt};
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_snd_cmd_host.sv
// tb_snd_cmd_host: randomized scoreboard bench for snd_cmd_host.
// A queue-level model predicts sends, reads and IRQ; a monitor compares.
module tb_snd_cmd_host;

  localparam int DEPTH = 4;
  localparam int PACE  = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n, paused, io_sel, io_wr, io_rd, irq_ack;
  logic [3:0]  io_addr;
  logic [15:0] io_din, io_dout;
  logic [1:0]  io_be;
  logic        irq_req, latch_wr, latch_rd, latch_rdy;
  logic [7:0]  latch_din, latch_dout;

  int errs = 0;
  int chks = 0;
  int cyc  = 0;

  typedef struct { logic [7:0] b; int t; } send_t;
  typedef struct { logic [7:0] b; int w; } ent_t;

  send_t       exp_send[$];
  logic [15:0] exp_rd[$];
  int          wr_times[$];
  bit          exp_irq_now;

  ent_t       mq[$];
  int         cum[int];
  int         last_s;
  bit         sent_any, m_ovf, m_irq, lr1, lr2;
  logic [7:0] m_reply;

  snd_cmd_host #(
    .FIFO_DEPTH (DEPTH),
    .PACE_CYCLES(PACE)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .paused    (paused),
    .io_sel    (io_sel),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .io_addr   (io_addr),
    .io_din    (io_din),
    .io_be     (io_be),
    .io_dout   (io_dout),
    .irq_req   (irq_req),
    .irq_ack   (irq_ack),
    .latch_wr  (latch_wr),
    .latch_din (latch_din),
    .latch_rd  (latch_rd),
    .latch_dout(latch_dout),
    .latch_rdy (latch_rdy)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a command may go out two cycles after its write,
  // and no earlier than PACE-2 unpaused cycles after the previous send's
  // cycle plus one idle cycle; replies land one cycle after latch_rdy is
  // first seen high.
  always @(negedge clk_sys) begin
    bit          snd, wcmd, rstat, rrep, cap;
    logic [15:0] dout;
    int          un;
    if (!reset_n) begin
      mq.delete();
      exp_send.delete();
      exp_rd.delete();
      sent_any    = 0;
      m_ovf       = 0;
      m_irq       = 0;
      lr1         = 0;
      lr2         = 0;
      m_reply     = 8'h00;
      exp_irq_now = 0;
    end else begin
      exp_irq_now = m_irq;
      wcmd  = io_sel && io_wr && io_be[0] && io_addr == 4'h0;
      rstat = io_sel && io_rd && io_addr == 4'hA;
      rrep  = io_sel && io_rd && io_addr == 4'h8;
      if (io_sel && io_rd) begin
        dout = 16'hffff;
        if (rrep) dout = {8'hff, m_reply};
        else if (rstat) dout = {8'hff, m_ovf, 2'b00, 5'(mq.size())};
        exp_rd.push_back(dout);
      end
      snd = 0;
      if (mq.size() > 0 && mq[0].w <= cyc - 2) begin
        if (!sent_any) snd = 1;
        else begin
          un = (cyc - 2 >= last_s) ? cum[cyc-2] - cum[last_s] : -1;
          if (un >= PACE - 2) snd = 1;
        end
      end
      if (snd) begin
        exp_send.push_back('{b: mq[0].b, t: cyc});
        void'(mq.pop_front());
        sent_any = 1;
        last_s   = cyc;
      end
      if (wcmd && mq.size() < DEPTH) mq.push_back('{b: io_din[7:0], w: cyc});
      if (wcmd && mq.size() >= DEPTH && !(mq.size() > 0 && mq[$].w == cyc))
        m_ovf = 1;
      else if (rstat) m_ovf = 0;
      cap = lr1 && !lr2;
      if (cap) begin
        m_reply = latch_dout;
        m_irq   = 1;
      end else if (rrep || irq_ack) m_irq = 0;
      lr2 = lr1;
      lr1 = latch_rdy;
    end
    cum[cyc] = (cum.exists(cyc - 1) ? cum[cyc-1] : 0) + (paused ? 0 : 1);
  end

  always @(negedge clk_sys) begin
    send_t s;
    #1;
    if (reset_n) begin
      check("irq_req", irq_req, exp_irq_now);
      if (io_sel && io_rd) begin
        if (exp_rd.size() == 0) check("rd_unexpected", io_dout, 16'hxxxx);
        else check("io_dout", io_dout, exp_rd.pop_front());
      end
      if (io_rd || latch_rd)
        check("latch_rd", latch_rd, io_sel && io_rd && io_addr == 4'h8);
      if (latch_wr) begin
        wr_times.push_back(cyc);
        if (exp_send.size() == 0) check("latch_wr_unexpected", latch_din, 32'hffffffff);
        else begin
          s = exp_send.pop_front();
          check("latch_wr_cycle", cyc, s.t);
          check("latch_din", latch_din, s.b);
        end
      end else if (exp_send.size() > 0 && exp_send[0].t <= cyc) begin
        check("latch_wr_missing", cyc, exp_send[0].t + 32'h10000000);
        void'(exp_send.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
    io_sel  = 0;
    io_wr   = 0;
    io_rd   = 0;
    irq_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [7:0] d,
                       input logic [1:0] be);
    io_sel  = 1;
    io_wr   = 1;
    io_addr = a;
    io_din  = {8'h5a, d};
    io_be   = be;
    step();
  endtask

  task automatic do_rd(input logic [3:0] a);
    io_sel  = 1;
    io_rd   = 1;
    io_addr = a;
    step();
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_io_dout"}, io_dout, 16'hffff);
    check({tag, "_irq_req"}, irq_req, 1'b0);
    check({tag, "_latch_wr"}, latch_wr, 1'b0);
    check({tag, "_latch_din"}, latch_din, 8'h00);
    check({tag, "_latch_rd"}, latch_rd, 1'b0);
  endtask

  initial begin
    int r;
    reset_n = 0; paused = 0; io_sel = 0; io_wr = 0; io_rd = 0;
    io_addr = 0; io_din = 0; io_be = 0; irq_ack = 0;
    latch_rdy = 0; latch_dout = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_outs("por");
    reset_n = 1;
    step();
    do_rd(4'h8);

    do_wr(4'h0, 8'h34, 2'b01);
    idle(3);
    do_rd(4'hA);

    for (int i = 1; i <= 5; i++) do_wr(4'h0, 8'(i), 2'b11);
    idle(50);
    do_rd(4'hA);

    for (int i = 1; i <= 6; i++) do_wr(4'h0, 8'(i), 2'b01);
    do_rd(4'hA);
    do_rd(4'hA);
    idle(50);

    latch_dout = 8'hA5;
    latch_rdy  = 1;
    idle(2);
    check("irq_after_rdy", irq_req, 1'b1);
    do_rd(4'h8);
    latch_rdy = 0;
    idle(3);

    latch_dout = 8'h5A;
    latch_rdy  = 1;
    step();
    do_rd(4'h8);
    check("irq_held_on_collision", irq_req, 1'b1);
    do_rd(4'h8);
    latch_rdy = 0;
    idle(3);

    latch_dout = 8'h3C;
    latch_rdy  = 1;
    idle(3);
    irq_ack = 1;
    step();
    latch_rdy = 0;
    idle(2);
    do_rd(4'h8);

    do_wr(4'h0, 8'h77, 2'b01);
    do_wr(4'h0, 8'h88, 2'b01);
    idle(2);
    paused = 1;
    idle(10);
    paused = 0;
    idle(20);
    if (wr_times.size() >= 2)
      check("pause_spacing", wr_times[$] - wr_times[$-1], 18);
    else check("pause_pulses", wr_times.size(), 2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      paused = ($urandom_range(0, 7) == 0);
      latch_dout = 8'($urandom);
      if ($urandom_range(0, 5) == 0) latch_rdy = ~latch_rdy;
      irq_ack = ($urandom_range(0, 9) == 0);
      if (r < 5) begin
        io_sel  = (r != 0);
        io_wr   = 1;
        io_addr = (r == 4) ? 4'h2 : 4'h0;
        io_be   = 2'($urandom);
        io_din  = 16'($urandom);
      end else if (r < 8) begin
        io_sel = 1;
        io_rd  = 1;
        case ($urandom_range(0, 4))
          0: io_addr = 4'h0;
          1: io_addr = 4'h8;
          2: io_addr = 4'hA;
          3: io_addr = 4'h2;
          default: io_addr = 4'hF;
        endcase
      end
      step();
    end
    paused = 0;
    latch_rdy = 0;
    idle(60);

    latch_dout = 8'hC3;
    latch_rdy  = 1;
    do_wr(4'h0, 8'hAA, 2'b01);
    do_wr(4'h0, 8'hBB, 2'b01);
    do_wr(4'h0, 8'hCC, 2'b01);
    idle(3);
    latch_rdy = 0;
    reset_n = 0;
    #1;
    chk_reset_outs("hold_rst");
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1;
    idle(20);
    do_rd(4'hA);
    do_rd(4'h8);
    idle(5);

    for (int i = 0; i < 500 && exp_send.size() > 0; i++) step();
    if (exp_send.size() > 0) check("drain_timeout", exp_send.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
